// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid register state encoding.
// The state value doubles as the occupancy count.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic logic can_accept(input state_e st);
        return st != ST_FULL;
    endfunction

endpackage

// File: rtl/skid_register.sv
// WIDTH-bit valid/ready pipeline register with one skid entry.
// Ready is registered so no combinational path runs from out_ready.
module skid_register
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic             accept, drain;

    assign accept = in_valid & rdy_q;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (accept && drain) begin
                    main_d  = in_data;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // flush overrides any transfer seen in the same cycle
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end
        rdy_d = can_accept(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_data  = main_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = 2'(state_q);

endmodule

// File: tb/tb_skid_register.sv
// Scoreboard bench for skid_register: the reference is a 2-deep FIFO queue;
// a separate monitor compares every drained word and the occupancy.
module tb_skid_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] occupancy;

    logic [7:0] c_in_data, mid_data, c_out_data;
    logic       c_in_valid, c_in_ready;
    logic       mid_valid, mid_ready;
    logic       c_out_valid, c_out_ready;
    logic [1:0] c_occ0, c_occ1;

    always #5 clk = ~clk;

    skid_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    skid_register #(.WIDTH(8), .RESET_VAL(8'h00)) u_st1 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(mid_data), .out_valid(mid_valid), .out_ready(mid_ready),
        .occupancy(c_occ0)
    );

    skid_register #(.WIDTH(8), .RESET_VAL(8'h00)) u_st2 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_data(mid_data), .in_valid(mid_valid), .in_ready(mid_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .occupancy(c_occ1)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];
    bit         mon_en = 0;
    bit         hold_chk = 0;
    logic [7:0] hold_val;
    int         got = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: FIFO model of capacity 2 predicts flags; drains pop in order
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en && !rst) begin
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (hold_chk) chk("stable_while_stalled", 32'(out_data), 32'(hold_val));
            hold_chk = out_valid && !out_ready && !flush;
            hold_val = out_data;
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) chk("spurious_output", 32'(out_data), 32'hFFFF);
                else chk("order", 32'(out_data), 32'(q.pop_front()));
                got++;
            end
        end else begin
            hold_chk = 0;
        end
    end

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                        input logic fl, output bit acc);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #2;
        acc = 0;
        if (fl) q.delete();
        else if (iv && in_ready) begin
            q.push_back(d);
            acc = 1;
        end
    endtask

    initial begin
        bit acc;
        int sent;
        int cyc;
        int seen;
        int bogus;
        logic [7:0] fact;

        rst = 1'b1; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        c_in_data = 8'h00; c_in_valid = 1'b0; c_out_ready = 1'b0;
        #1;
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        // streaming, one word per cycle
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("stream_count", 32'(got), 32'd16);

        // backpressure into the skid entry
        step(1'b1, 8'hA5, 1'b0, 1'b0, acc);
        step(1'b1, 8'h5A, 1'b0, 1'b0, acc);
        step(1'b1, 8'h77, 1'b0, 1'b0, acc);
        chk("full_occupancy", 32'(occupancy), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_data", 32'(out_data), 32'hA5);
        chk("third_held_off", 32'(acc), 32'd0);
        cyc = 0;
        do begin
            step(1'b1, 8'h77, 1'b1, 1'b0, acc);
            cyc++;
        end while (!acc && cyc < 10);
        chk("third_accepted", 32'(acc), 32'd1);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("skid_drained", 32'(q.size()), 32'd0);

        // flush while full, with coincident transfers requested
        step(1'b1, 8'h11, 1'b0, 1'b0, acc);
        step(1'b1, 8'h22, 1'b0, 1'b0, acc);
        step(1'b1, 8'h33, 1'b1, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'h00);

        // asynchronous reset in mid-cycle with a word held
        step(1'b1, 8'h9C, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        mon_en = 0;
        rst = 1'b1;
        #1;
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'h00);
        q.delete();
        hold_chk = 0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        // randomized traffic
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'b0, acc);
            if (acc) sent++;
            cyc++;
        end
        chk("random_sent", 32'(sent), 32'd1000);
        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, acc);
            cyc++;
        end
        chk("random_drained", 32'(q.size()), 32'd0);

        // 5! through two chained stages, output stalled every 3rd cycle
        fact = 8'd1;
        for (int i = 2; i <= 5; i++) fact = 8'(fact * 8'(i));
        seen = 0;
        bogus = 0;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            c_in_valid  = !acc;
            c_in_data   = fact;
            c_out_ready = (c % 3) != 2;
            #1;
            if (c_out_valid && c_out_ready) begin
                if (c_out_data == 8'd120) seen++;
                else bogus++;
            end
            if (c_in_valid && c_in_ready) acc = 1;
        end
        c_in_valid = 1'b0;
        chk("fact_seen_once", 32'(seen), 32'd1);
        chk("fact_no_other", 32'(bogus), 32'd0);

        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
